// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART TX arbiter.
// State encoding is fixed so waveforms read the same across tools.
package uart_tx_arbiter_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        UART_ARB_IDLE      = 2'd0,
        UART_ARB_START     = 2'd1,
        UART_ARB_WAIT_BUSY = 2'd2,
        UART_ARB_WAIT_DONE = 2'd3
    } arb_state_t;

    // Next round-robin position after id, wrapping at n.
    function automatic int unsigned rr_next(
        input int unsigned id,
        input int unsigned n
    );
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte handshakes plus the uart_tx start/busy handshake.
// master is the arbiter side, slave is the requesters and transmitter.
interface uart_tx_arbiter_if
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*BYTE_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_start;
    logic [BYTE_W-1:0]         tx_data;
    logic                      tx_busy;
    logic                      grant_valid;
    logic [IW-1:0]             grant_id;
    logic                      timeout_err;

    modport master (
        input  req_valid, req_data, req_lock, tx_busy,
        output req_ready, tx_start, tx_data,
        output grant_valid, grant_id, timeout_err
    );

    modport slave (
        output req_valid, req_data, req_lock, tx_busy,
        input  req_ready, tx_start, tx_data,
        input  grant_valid, grant_id, timeout_err
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or
// above ptr, wrapping past the top index.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_idx,
    output logic               any
);

    logic [IW-1:0] w_idx;
    logic          w_found;

    // Scan upward from ptr and keep the first hit.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = IW'((32'(ptr) + 32'(k)) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                gnt_idx = w_idx;
            end
        end
        if (w_found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte sources, one byte per
// frame, with optional grant lock and a tx_busy timeout.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 64
) (
    input logic               clk,
    input logic               rst,
    uart_tx_arbiter_if.master bus
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(BUSY_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

    arb_state_t        r_state;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_grant_id;
    logic              r_lock;
    logic              r_tx_start;
    logic              r_grant_valid;
    logic              r_timeout_err;
    logic [CW-1:0]     r_cnt;
    logic [BYTE_W-1:0] r_tx_data;

    logic               w_lock_hit;
    logic               w_any;
    logic               w_xfer;
    logic [NUM_REQ-1:0] w_pick_req;
    logic [NUM_REQ-1:0] w_gnt;
    logic [NUM_REQ-1:0] w_ready;
    logic [IW-1:0]      w_idx;
    logic [IW-1:0]      w_ptr_next;

    // A held lock with its owner still valid makes the owner the
    // only candidate; otherwise all valid requesters compete.
    always_comb begin
        w_lock_hit = r_lock & bus.req_valid[r_grant_id];
        w_pick_req = bus.req_valid;
        if (w_lock_hit) begin
            w_pick_req             = '0;
            w_pick_req[r_grant_id] = 1'b1;
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (w_pick_req),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_idx),
        .any     (w_any)
    );

    // Offer the winner only while idle with the transmitter free.
    always_comb begin
        w_ready = '0;
        if (!rst && r_state == UART_ARB_IDLE
            && !bus.tx_busy && w_any) begin
            w_ready = w_gnt;
        end
    end

    assign w_xfer     = |(w_ready & bus.req_valid);
    assign w_ptr_next = IW'(rr_next(32'(r_grant_id), NUM_REQ));

    // Frame sequencing, timeout counter, lock and rr pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= UART_ARB_IDLE;
            r_ptr         <= '0;
            r_grant_id    <= '0;
            r_lock        <= 1'b0;
            r_tx_start    <= 1'b0;
            r_grant_valid <= 1'b0;
            r_timeout_err <= 1'b0;
            r_cnt         <= '0;
            r_tx_data     <= '0;
        end else begin
            r_tx_start    <= 1'b0;
            r_timeout_err <= 1'b0;
            unique case (r_state)
                UART_ARB_IDLE: begin
                    if (w_xfer) begin
                        r_tx_data     <= bus.req_data[{w_idx, 3'b000} +: BYTE_W];
                        r_grant_id    <= w_idx;
                        r_lock        <= bus.req_lock[w_idx];
                        r_tx_start    <= 1'b1;
                        r_grant_valid <= 1'b1;
                        r_state       <= UART_ARB_START;
                    end else if (r_lock && !w_lock_hit) begin
                        r_lock <= 1'b0;
                    end
                end
                UART_ARB_START: begin
                    r_cnt   <= '0;
                    r_state <= UART_ARB_WAIT_BUSY;
                end
                UART_ARB_WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        r_state <= UART_ARB_WAIT_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_cnt         <= CNT_MAX;
                        r_timeout_err <= 1'b1;
                        r_lock        <= 1'b0;
                        r_ptr         <= w_ptr_next;
                        r_grant_valid <= 1'b0;
                        r_state       <= UART_ARB_IDLE;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                UART_ARB_WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        r_ptr         <= w_ptr_next;
                        r_grant_valid <= 1'b0;
                        r_state       <= UART_ARB_IDLE;
                    end
                end
                default: begin
                    r_state <= UART_ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.tx_start    = r_tx_start;
    assign bus.tx_data     = r_tx_data;
    assign bus.grant_valid = r_grant_valid;
    assign bus.grant_id    = r_grant_id;
    assign bus.timeout_err = r_timeout_err;

endmodule
